// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: page copy to the OAM data port with CPU stall
// Optional ALIGN state and parity tracking are built when OAM_DMA_ALIGN_EN is defined.
module oam_dma #(
   parameter int                    ADDR_WIDTH    = 16,
   parameter int                    REG_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR  = 16'h4014,
   parameter logic [ADDR_WIDTH-1:0] OAM_PORT_ADDR = 16'h2004,
   parameter int                    XFER_LEN      = 256
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [REG_WIDTH-1:0]  cpu_wdata,
   input  logic                  cpu_we,
   input  logic [REG_WIDTH-1:0]  dma_rdata,
   output logic                  rdy,
   output logic                  bus_grant,
   output logic [ADDR_WIDTH-1:0] dma_addr,
   output logic [REG_WIDTH-1:0]  dma_wdata,
   output logic                  dma_we,
   output logic                  busy,
   output logic                  dma_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t               state;
   logic [7:0]           idx;
   logic [REG_WIDTH-1:0] page;
   logic [REG_WIDTH-1:0] data_q;
`ifdef OAM_DMA_ALIGN_EN
   logic                 parity;
`endif

   logic trigger;
   assign trigger   = cpu_we && (cpu_addr == TRIGGER_ADDR);
   assign dma_wdata = data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         page      <= '0;
         data_q    <= '0;
         rdy       <= 1'b1;
         bus_grant <= 1'b0;
         dma_addr  <= '0;
         dma_we    <= 1'b0;
         busy      <= 1'b0;
         dma_done  <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
         parity    <= 1'b0;
`endif
      end else begin
`ifdef OAM_DMA_ALIGN_EN
         parity   <= ~parity;
`endif
         dma_done <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  page  <= cpu_wdata;
                  idx   <= '0;
                  rdy   <= 1'b0;
                  busy  <= 1'b1;
                  state <= HALT;
               end
            end
            HALT: begin
               // The CPU finishes its in-flight cycle here; the bus is ours from the next cycle.
               bus_grant <= 1'b1;
               dma_we    <= 1'b0;
               dma_addr  <= {page, idx};
`ifdef OAM_DMA_ALIGN_EN
               state     <= parity ? ALIGN : READ;
`else
               state     <= READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
               state <= READ;
            end
`endif
            READ: begin
               data_q   <= dma_rdata;
               dma_we   <= 1'b1;
               dma_addr <= OAM_PORT_ADDR;
               state    <= WRITE;
            end
            WRITE: begin
               if (idx == LAST_IDX) begin
                  rdy       <= 1'b1;
                  bus_grant <= 1'b0;
                  dma_we    <= 1'b0;
                  busy      <= 1'b0;
                  dma_done  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  // idx wraps inside the page; the page byte is never incremented.
                  idx      <= idx + 8'd1;
                  dma_we   <= 1'b0;
                  dma_addr <= {page, idx + 8'd1};
                  state    <= READ;
               end
            end
            default: begin
               rdy       <= 1'b1;
               bus_grant <= 1'b0;
               dma_we    <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
